fetch_sequencer: RTL and testbench

Instruction-fetch and phase sequencer for the 4-bit CPU. It feeds the microcode decoder with the opcode, the `phase` bit and the C/Z flags, and consumes the decoder's PC-load and flag-load strobes. It owns the 12-bit program counter, the instruction register, the two-byte jump-address fetch and the flag registers. It sits between the program ROM and the combinational decoder.

---
 rtl/nibbler_pkg.sv | 35 +++
 rtl/fetch_sequencer_program_counter.sv | 47 ++++
 rtl/fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// rtl/nibbler_pkg.sv - shared opcodes, sequencer state type and jump classifier
package nibbler_pkg;

    localparam int PC_W_DEF = 12;

    localparam logic [3:0] OP_JC    = 4'd0;
    localparam logic [3:0] OP_JNC   = 4'd1;
    localparam logic [3:0] OP_CMPI  = 4'd2;
    localparam logic [3:0] OP_CMPM  = 4'd3;
    localparam logic [3:0] OP_LIT   = 4'd4;
    localparam logic [3:0] OP_IN    = 4'd5;
    localparam logic [3:0] OP_OUT   = 4'd6;
    localparam logic [3:0] OP_ST    = 4'd7;
    localparam logic [3:0] OP_JZ    = 4'd8;
    localparam logic [3:0] OP_JNZ   = 4'd9;
    localparam logic [3:0] OP_LD    = 4'd10;
    localparam logic [3:0] OP_ADDM  = 4'd11;
    localparam logic [3:0] OP_JMP   = 4'd12;
    localparam logic [3:0] OP_SUBM  = 4'd13;
    localparam logic [3:0] OP_NANDM = 4'd14;
    localparam logic [3:0] OP_NORM  = 4'd15;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ADDR  = 2'd1,
        EXEC  = 2'd2
    } seq_state_t;

    // Jump-class opcodes carry a second byte holding the low 8 address bits.
    function automatic logic is_jump(input logic [3:0] op);
        return (op == OP_JC) || (op == OP_JNC) || (op == OP_JZ) ||
               (op == OP_JNZ) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// rtl/fetch_sequencer_program_counter.sv - program counter with increment, load and run enable
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset (clears pc to 0)
//   run             : 0 holds pc regardless of inc/load
//   inc             : pc <= pc + 1 (wraps modulo 2^PC_W)
//   load, load_val  : pc <= load_val; takes priority over inc
//   pc              : current program counter
module program_counter
    import nibbler_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (run) begin
            if (load) begin
                pc_d = load_val;
            end else if (inc) begin
                pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch / phase sequencer for the 4-bit CPU
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   run                 : 1 advances, 0 freezes all state
//   rom_data / rom_addr : program ROM byte (combinational read) and its address (= pc)
//   load_pc, load_flag  : decoder strobes, honoured only in EXEC
//   c_in, z_in          : ALU flags captured on load_flag
//   i, oprnd            : opcode and operand nibbles of the instruction register
//   phase               : 1 during EXEC
//   c, z                : flag registers
//   pc                  : program counter
module fetch_sequencer
    import nibbler_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [7:0]      rom_data,
    output logic [PC_W-1:0] rom_addr,
    input  logic            load_pc,
    input  logic            load_flag,
    input  logic            c_in,
    input  logic            z_in,
    output logic [3:0]      i,
    output logic [3:0]      oprnd,
    output logic            phase,
    output logic            c,
    output logic            z,
    output logic [PC_W-1:0] pc
);

    seq_state_t state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] addr_lo_q, addr_lo_d;
    logic       c_q, c_d;
    logic       z_q, z_d;

    logic ir_we, addr_we, pc_inc, pc_load, flag_we;
    logic [PC_W-1:0] jump_target;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (run) begin
            case (state_q)
                FETCH:   state_d = is_jump(rom_data[7:4]) ? ADDR : EXEC;
                ADDR:    state_d = EXEC;
                EXEC:    state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // Output / datapath-control decode; strobes only count in EXEC
    always_comb begin
        ir_we   = 1'b0;
        addr_we = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        flag_we = 1'b0;
        phase   = 1'b0;
        case (state_q)
            FETCH: begin
                ir_we  = 1'b1;
                pc_inc = 1'b1;
            end
            ADDR: begin
                addr_we = 1'b1;
                pc_inc  = 1'b1;
            end
            EXEC: begin
                phase   = 1'b1;
                pc_load = load_pc;
                flag_we = load_flag;
            end
            default: ;
        endcase
    end

    always_comb begin
        ir_d      = ir_q;
        addr_lo_d = addr_lo_q;
        c_d       = c_q;
        z_d       = z_q;
        if (run) begin
            if (ir_we)   ir_d      = rom_data;
            if (addr_we) addr_lo_d = rom_data;
            if (flag_we) begin
                c_d = c_in;
                z_d = z_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q      <= 8'h00;
            addr_lo_q <= 8'h00;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            addr_lo_q <= addr_lo_d;
            c_q       <= c_d;
            z_q       <= z_d;
        end
    end

    // Target is {operand nibble, second byte}; a non-jump load uses whatever addr_lo holds.
    always_comb begin
        jump_target = '0;
        jump_target[11:0] = {ir_q[3:0], addr_lo_q};
    end

    program_counter #(
        .PC_W(PC_W)
    ) u_program_counter (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (jump_target),
        .pc       (pc)
    );

    assign rom_addr = pc;
    assign i        = ir_q[7:4];
    assign oprnd    = ir_q[3:0];
    assign c        = c_q;
    assign z        = z_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [7:0]  rom_data;
    logic [11:0] rom_addr;
    logic        load_pc;
    logic        load_flag;
    logic        c_in;
    logic        z_in;
    logic [3:0]  i;
    logic [3:0]  oprnd;
    logic        phase;
    logic        c;
    logic        z;
    logic [11:0] pc;

    logic [7:0] rom [0:4095];

    int tests_run;
    int tests_failed;

    fetch_sequencer #(.PC_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .rom_data  (rom_data),
        .rom_addr  (rom_addr),
        .load_pc   (load_pc),
        .load_flag (load_flag),
        .c_in      (c_in),
        .z_in      (z_in),
        .i         (i),
        .oprnd     (oprnd),
        .phase     (phase),
        .c         (c),
        .z         (z),
        .pc        (pc)
    );

    assign rom_data = rom[rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int k = 0; k < 4096; k++) rom[k] = 8'h00;
        reset     = 1'b1;
        run       = 1'b1;
        load_pc   = 1'b0;
        load_flag = 1'b0;
        c_in      = 1'b0;
        z_in      = 1'b0;

        // Reset state
        do_reset();
        check("rst_pc", pc, 12'h000);
        check("rst_rom_addr", rom_addr, 12'h000);
        check("rst_i", i, 4'h0);
        check("rst_oprnd", oprnd, 4'h0);
        check("rst_phase", phase, 1'b0);
        check("rst_c", c, 1'b0);
        check("rst_z", z, 1'b0);

        // CMPI 0xA with flag load
        rom[0] = 8'h2A;
        load_flag = 1'b1; c_in = 1'b1; z_in = 1'b0;
        do_reset();
        check("cmpi_fetch_phase", phase, 1'b0);
        step();
        check("cmpi_exec_phase", phase, 1'b1);
        check("cmpi_exec_pc", pc, 12'h001);
        check("cmpi_i", i, 4'h2);
        check("cmpi_oprnd", oprnd, 4'hA);
        check("cmpi_c_before", c, 1'b0);
        step();
        check("cmpi_c", c, 1'b1);
        check("cmpi_z", z, 1'b0);
        check("cmpi_pc", pc, 12'h001);
        check("cmpi_phase_after", phase, 1'b0);
        load_flag = 1'b0;

        // JMP 0x345, load_pc held high throughout (ignored outside EXEC)
        rom[0] = 8'hC3; rom[1] = 8'h45;
        load_pc = 1'b1;
        do_reset();
        step();
        check("jmp_addr_pc", pc, 12'h001);
        check("jmp_addr_phase", phase, 1'b0);
        check("jmp_i", i, 4'hC);
        step();
        check("jmp_exec_pc", pc, 12'h002);
        check("jmp_exec_phase", phase, 1'b1);
        step();
        check("jmp_target_pc", pc, 12'h345);
        check("jmp_target_rom_addr", rom_addr, 12'h345);
        check("jmp_fetch_phase", phase, 1'b0);
        load_pc = 1'b0;

        // JZ not taken
        rom[0] = 8'h81; rom[1] = 8'h23;
        do_reset();
        step();
        check("jz_addr_pc", pc, 12'h001);
        check("jz_addr_phase", phase, 1'b0);
        step();
        check("jz_exec_phase", phase, 1'b1);
        step();
        check("jz_after_pc", pc, 12'h002);
        check("jz_after_phase", phase, 1'b0);

        // Wrap from 0xFFF: reach it by JMP 0xFFF, then IN at 0xFFF
        rom[0] = 8'hCF; rom[1] = 8'hFF; rom[12'hFFF] = 8'h50;
        load_pc = 1'b1;
        do_reset();
        step(); step(); step();
        load_pc = 1'b0;
        check("wrap_at_fff", pc, 12'hFFF);
        step();
        check("wrap_pc", pc, 12'h000);
        check("wrap_phase", phase, 1'b1);
        check("wrap_i", i, 4'h5);
        step();
        check("wrap_next_pc", pc, 12'h000);
        check("wrap_next_phase", phase, 1'b0);

        // Stall in ADDR for 3 cycles
        rom[0] = 8'hC3; rom[1] = 8'h45;
        load_pc = 1'b1;
        do_reset();
        step();
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_pc", pc, 12'h001);
            check("stall_i", i, 4'hC);
            check("stall_phase", phase, 1'b0);
        end
        run = 1'b1;
        step();
        check("resume_exec_pc", pc, 12'h002);
        check("resume_exec_phase", phase, 1'b1);
        step();
        check("resume_target_pc", pc, 12'h345);
        load_pc = 1'b0;

        // Asynchronous reset mid-EXEC with both strobes set
        rom[0] = 8'h2A;
        do_reset();
        load_pc = 1'b1; load_flag = 1'b1; c_in = 1'b1; z_in = 1'b1;
        step();
        check("arst_in_exec", phase, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_phase", phase, 1'b0);
        check("arst_pc", pc, 12'h000);
        check("arst_i", i, 4'h0);
        check("arst_c", c, 1'b0);
        check("arst_z", z, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_rel_pc", pc, 12'h000);
        check("arst_rel_c", c, 1'b0);
        check("arst_rel_z", z, 1'b0);
        check("arst_rel_phase", phase, 1'b0);
        load_pc = 1'b0; load_flag = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
